// File: rtl/p2s_pkg.sv
// Shared definitions for the parallel-to-serial transmitter and the downstream parity checker.
package p2s_pkg;

    // Serialiser state encodings; 2'd3 is unused and treated as illegal.
    localparam logic [1:0] P2S_IDLE  = 2'd0;
    localparam logic [1:0] P2S_SHIFT = 2'd1;
    localparam logic [1:0] P2S_PAR   = 2'd2;

    // Parity modes: even parity bit = ^word, odd parity bit = ~^word.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

endpackage

// File: rtl/p2s_parity_tx_parity_gen.sv
// Combinational reduction of a word to a single parity bit.
module parity_gen
    import p2s_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int ODD   = 0
) (
    input  logic [WIDTH-1:0] word,
    output logic             par
);

    // Odd mode inverts the XOR reduction so the word plus parity holds an odd number of ones.
    assign par = (ODD == int'(PAR_ODD)) ? ~^word : ^word;

endmodule

// File: rtl/p2s_parity_tx.sv
// Serialiser: accepts a parallel word over valid/ready, emits it one bit per clock,
// optionally followed by a parity symbol. A word offered during the last symbol
// starts the next frame with no gap.
//
// state     | meaning
// P2S_IDLE  | no frame in flight, ready for a word
// P2S_SHIFT | data symbol number cnt is on sout
// P2S_PAR   | parity symbol is on sout (always the last symbol)
module p2s_parity_tx #(
    parameter int WIDTH     = 4,
    parameter int MSB_FIRST = 0,
    parameter int PAR_EN    = 1,
    parameter int PAR_ODD   = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             sout_last,
    output logic             busy
);
    import p2s_pkg::*;

    localparam int             CW           = $clog2(WIDTH + 2);
    localparam logic [CW-1:0]  CNT_DATA_END = CW'(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] shift_reg;
    logic [WIDTH-1:0] word_q;
    logic             par_bit;
    logic             accept;
    logic             first_bit;
    logic             next_bit;
    logic [WIDTH-1:0] din_shifted;
    logic [WIDTH-1:0] reg_shifted;

    // Parity is taken from the held copy of the word, so din changes mid-frame cannot leak in.
    parity_gen #(
        .WIDTH (WIDTH),
        .ODD   (PAR_ODD)
    ) u_parity_gen (
        .word (word_q),
        .par  (par_bit)
    );

    assign din_ready = ~rst & ((state == P2S_IDLE) | sout_last);
    assign busy      = (state != P2S_IDLE);
    assign accept    = din_valid & din_ready;

    // The first bit goes straight from din to sout; the shift register keeps the rest.
    assign first_bit   = (MSB_FIRST != 0) ? din[WIDTH-1] : din[0];
    assign next_bit    = (MSB_FIRST != 0) ? shift_reg[WIDTH-1] : shift_reg[0];
    assign din_shifted = (MSB_FIRST != 0) ? (din << 1) : (din >> 1);
    assign reg_shifted = (MSB_FIRST != 0) ? (shift_reg << 1) : (shift_reg >> 1);

    // Frame sequencing: state, symbol counter, shift register and registered serial outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= P2S_IDLE;
            cnt        <= '0;
            shift_reg  <= '0;
            word_q     <= '0;
            sout       <= 1'b0;
            sout_valid <= 1'b0;
            sout_last  <= 1'b0;
        end else if (accept) begin
            state      <= P2S_SHIFT;
            cnt        <= CW'(1);
            word_q     <= din;
            shift_reg  <= din_shifted;
            sout       <= first_bit;
            sout_valid <= 1'b1;
            sout_last  <= 1'b0;
        end else begin
            case (state)
                P2S_SHIFT: begin
                    if (cnt != CNT_DATA_END) begin
                        sout      <= next_bit;
                        shift_reg <= reg_shifted;
                        cnt       <= cnt + CW'(1);
                        sout_last <= (PAR_EN == 0) && ((cnt + CW'(1)) == CNT_DATA_END);
                    end else if (PAR_EN != 0) begin
                        state     <= P2S_PAR;
                        sout      <= par_bit;
                        sout_last <= 1'b1;
                        cnt       <= cnt + CW'(1);
                    end else begin
                        state      <= P2S_IDLE;
                        cnt        <= '0;
                        sout       <= 1'b0;
                        sout_valid <= 1'b0;
                        sout_last  <= 1'b0;
                    end
                end
                default: begin
                    // Idle, end of parity symbol without a new word, or illegal encoding.
                    state      <= P2S_IDLE;
                    cnt        <= '0;
                    sout       <= 1'b0;
                    sout_valid <= 1'b0;
                    sout_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p2s_parity_tx.sv
// Bench for p2s_parity_tx: three configurations, directed and random frames,
// expected symbols built from the word, bit order and parity rule.
module tb_p2s_parity_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] din_a, din_b, din_c;
    logic [2:0] dv;
    logic [2:0] ready, sout, sv, sl, busy;

    int errors = 0;
    int checks = 0;

    logic exp_bit[$];
    logic exp_last[$];

    always #5 clk = ~clk;

    // a: defaults; b: MSB first without parity; c: odd parity
    p2s_parity_tx #(.WIDTH(4), .MSB_FIRST(0), .PAR_EN(1), .PAR_ODD(0)) dut_a (
        .clk(clk), .rst(rst), .din(din_a), .din_valid(dv[0]), .din_ready(ready[0]),
        .sout(sout[0]), .sout_valid(sv[0]), .sout_last(sl[0]), .busy(busy[0]));
    p2s_parity_tx #(.WIDTH(4), .MSB_FIRST(1), .PAR_EN(0), .PAR_ODD(0)) dut_b (
        .clk(clk), .rst(rst), .din(din_b), .din_valid(dv[1]), .din_ready(ready[1]),
        .sout(sout[1]), .sout_valid(sv[1]), .sout_last(sl[1]), .busy(busy[1]));
    p2s_parity_tx #(.WIDTH(4), .MSB_FIRST(0), .PAR_EN(1), .PAR_ODD(1)) dut_c (
        .clk(clk), .rst(rst), .din(din_c), .din_valid(dv[2]), .din_ready(ready[2]),
        .sout(sout[2]), .sout_valid(sv[2]), .sout_last(sl[2]), .busy(busy[2]));

    task automatic chk(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic set_in(input int s, input logic [3:0] d, input logic v);
        case (s)
            0:       din_a = d;
            1:       din_b = d;
            default: din_c = d;
        endcase
        dv[s] = v;
    endtask

    // Reference: list the symbols a word produces under configuration s.
    task automatic push_frame(input int s, input logic [3:0] w);
        int msb  = (s == 1) ? 1 : 0;
        int pen  = (s == 1) ? 0 : 1;
        int odd  = (s == 2) ? 1 : 0;
        int ones = 0;
        int n    = 4 + pen;
        for (int i = 0; i < 4; i++) begin
            exp_bit.push_back(msb != 0 ? w[3 - i] : w[i]);
            exp_last.push_back(i == n - 1);
            ones += int'(w[i]);
        end
        if (pen != 0) begin
            exp_bit.push_back(logic'((ones % 2) ^ odd));
            exp_last.push_back(1'b1);
        end
    endtask

    task automatic check_idle(input int s, input string tag);
        chk({tag, "_valid"}, sv[s], 1'b0);
        chk({tag, "_sout"},  sout[s], 1'b0);
        chk({tag, "_last"},  sl[s], 1'b0);
        chk({tag, "_busy"},  busy[s], 1'b0);
        chk({tag, "_ready"}, ready[s], 1'b1);
    endtask

    // Offer n words back to back on DUT s; scribble on din/din_valid while not ready.
    task automatic stream(input int s, input int n, input logic [3:0] w0,
                          input logic [3:0] w1, input logic [3:0] w2, input string tag);
        logic [3:0] w[3];
        int nxt = 1;
        w[0] = w0; w[1] = w1; w[2] = w2;
        exp_bit.delete();
        exp_last.delete();
        for (int j = 0; j < n; j++) push_frame(s, w[j]);
        set_in(s, w[0], 1'b1);
        for (int k = 0; k < exp_bit.size(); k++) begin
            @(posedge clk); #1;
            chk($sformatf("%s_sym%0d_valid", tag, k), sv[s], 1'b1);
            chk($sformatf("%s_sym%0d_bit", tag, k), sout[s], exp_bit[k]);
            chk($sformatf("%s_sym%0d_last", tag, k), sl[s], exp_last[k]);
            chk($sformatf("%s_sym%0d_ready", tag, k), ready[s], exp_last[k]);
            chk($sformatf("%s_sym%0d_busy", tag, k), busy[s], 1'b1);
            if (exp_last[k]) begin
                if (nxt < n) begin
                    set_in(s, w[nxt], 1'b1);
                    nxt++;
                end else begin
                    set_in(s, 4'($urandom), 1'b0);
                end
            end else begin
                set_in(s, 4'($urandom), 1'($urandom_range(0, 1)));
            end
        end
        @(posedge clk); #1;
        check_idle(s, {tag, "_end"});
    endtask

    initial begin
        rst   = 1'b1;
        din_a = 4'b1011; din_b = 4'b0000; din_c = 4'b0000;
        dv    = 3'b001;

        // Reset held two cycles with a word offered
        for (int c = 0; c < 2; c++) begin
            @(posedge clk); #1;
            chk("rst_ready", ready[0], 1'b0);
            chk("rst_valid", sv[0], 1'b0);
            chk("rst_sout",  sout[0], 1'b0);
            chk("rst_last",  sl[0], 1'b0);
        end
        rst = 1'b0;
        #1;
        chk("rel_ready", ready[0], 1'b1);
        chk("rel_busy",  busy[0], 1'b0);

        // Single frame, then back-to-back pair
        stream(0, 1, 4'b1011, 4'b0000, 4'b0000, "single");
        stream(0, 2, 4'b1011, 4'b0110, 4'b0000, "b2b");

        // MSB first, no parity
        stream(1, 1, 4'b1000, 4'b0000, 4'b0000, "msb");

        // Mid-frame reset after two symbols
        set_in(0, 4'b1011, 1'b1);
        @(posedge clk); #1;
        chk("mid_s1", sout[0], 1'b1);
        set_in(0, 4'b1011, 1'b0);
        @(posedge clk); #1;
        chk("mid_s2", sout[0], 1'b1);
        chk("mid_s2_valid", sv[0], 1'b1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("mid_rst_valid", sv[0], 1'b0);
        chk("mid_rst_sout",  sout[0], 1'b0);
        chk("mid_rst_busy",  busy[0], 1'b0);
        chk("mid_rst_ready", ready[0], 1'b0);
        rst = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            check_idle(0, "mid_after");
        end
        stream(0, 1, 4'b0001, 4'b0000, 4'b0000, "mid_new");

        // Odd parity with din toggling mid-frame
        stream(2, 1, 4'b0000, 4'b0000, 4'b0000, "odd");

        // Random frames on every configuration
        for (int s = 0; s < 3; s++) begin
            for (int r = 0; r < 4; r++) begin
                stream(s, int'($urandom_range(1, 3)), 4'($urandom), 4'($urandom),
                       4'($urandom), $sformatf("rnd%0d_%0d", s, r));
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
